// File: rtl/spi_slave_sck_ctrl.sv
// rtl/spi_slave_sck_ctrl.sv - SPI slave SCK/SS_n synchroniser producing shift/sample strobes and frame count
// Optional build macro SCK_IDLE_CHECK_EN adds the sticky mode_err idle-level check output.
module spi_slave_sck_ctrl #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  SYNC_STAGES = 2,
    localparam int CNT_W       = $clog2(DATA_WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCK_in,
    input  logic             SS_n,
    input  logic             CPOL,
    input  logic             CPHA,
    output logic             Shift_clk,
    output logic             Sample_clk,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done,
`ifdef SCK_IDLE_CHECK_EN
    output logic             mode_err,
`endif
    output logic             active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   shift_q, shift_d;
    logic                   sample_q, sample_d;
    logic                   frame_done_q, frame_done_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
`ifdef SCK_IDLE_CHECK_EN
    logic                   mode_err_q, mode_err_d;
`endif

    logic sck_now;
    logic ss_now;
    logic lead;
    logic trail;

    assign sck_now = sck_sync_q[SYNC_STAGES-1];
    assign ss_now  = ss_sync_q[SYNC_STAGES-1];
    assign lead    = (sck_hist_q == CPOL) && (sck_now != CPOL);
    assign trail   = (sck_hist_q != CPOL) && (sck_now == CPOL);

    always_comb begin
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], SCK_in};
        ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
        sck_hist_d   = sck_now;
        state_d      = state_q;
        shift_d      = 1'b0;
        sample_d     = 1'b0;
        frame_done_d = 1'b0;
        bit_cnt_d    = bit_cnt_q;
`ifdef SCK_IDLE_CHECK_EN
        mode_err_d   = mode_err_q;
`endif
        // Deselect dominates any SCK edge seen in the same cycle.
        if (ss_now) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARMED;
                    bit_cnt_d = '0;
                    shift_d   = !CPHA;
`ifdef SCK_IDLE_CHECK_EN
                    mode_err_d = (sck_now != CPOL);
`endif
                end
                default: begin
                    if (frame_done_q) begin
                        bit_cnt_d = '0;
                    end
                    // ARMED still honours the trail after the last sample so the next byte loads.
                    if (lead) begin
                        state_d  = ST_XFER;
                        shift_d  = CPHA;
                        sample_d = !CPHA;
                    end else if (trail) begin
                        shift_d  = !CPHA;
                        sample_d = CPHA;
                    end
                end
            endcase
`ifdef SCK_IDLE_CHECK_EN
            if (mode_err_d) begin
                shift_d  = 1'b0;
                sample_d = 1'b0;
            end
`endif
            if (sample_d) begin
                if (bit_cnt_d == CNT_W'(DATA_WIDTH - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_ARMED;
                end
                bit_cnt_d = bit_cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            sck_hist_q   <= 1'b0;
            shift_q      <= 1'b0;
            sample_q     <= 1'b0;
            frame_done_q <= 1'b0;
            bit_cnt_q    <= '0;
`ifdef SCK_IDLE_CHECK_EN
            mode_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sck_sync_q   <= sck_sync_d;
            ss_sync_q    <= ss_sync_d;
            sck_hist_q   <= sck_hist_d;
            shift_q      <= shift_d;
            sample_q     <= sample_d;
            frame_done_q <= frame_done_d;
            bit_cnt_q    <= bit_cnt_d;
`ifdef SCK_IDLE_CHECK_EN
            mode_err_q   <= mode_err_d;
`endif
        end
    end

    assign Shift_clk  = shift_q;
    assign Sample_clk = sample_q;
    assign frame_done = frame_done_q;
    assign bit_cnt    = bit_cnt_q;
    assign active     = (state_q != ST_IDLE);
`ifdef SCK_IDLE_CHECK_EN
    assign mode_err   = mode_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_sck_ctrl.sv
// tb/tb_spi_slave_sck_ctrl.sv - randomized self-checking bench for spi_slave_sck_ctrl
module tb_spi_slave_sck_ctrl;

    localparam int DW = 8;
    localparam int CW = $clog2(DW) + 1;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck_in = 1'b0;
    logic          ss_n = 1'b1;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          shift_clk;
    logic          sample_clk;
    logic          frame_done;
    logic          active;
    logic [CW-1:0] bit_cnt;
`ifdef SCK_IDLE_CHECK_EN
    logic          mode_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit q_ss[$];
    bit q_sck[$];
    bit m_err = 1'b0;
    int obs_sh;
    int obs_sa;
    int obs_fd;

    spi_slave_sck_ctrl #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SCK_in     (sck_in),
        .SS_n       (ss_n),
        .CPOL       (cpol),
        .CPHA       (cpha),
        .Shift_clk  (shift_clk),
        .Sample_clk (sample_clk),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done),
`ifdef SCK_IDLE_CHECK_EN
        .mode_err   (mode_err),
`endif
        .active     (active)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic q_clear();
        q_ss.delete();
        q_sck.delete();
    endtask

    task automatic push(input bit s, input bit k, input int n);
        repeat (n) begin
            q_ss.push_back(s);
            q_sck.push_back(k);
        end
    endtask

    task automatic push_bits(input int nb);
        for (int i = 0; i < nb; i++) begin
            push(1'b0, !cpol, int'($urandom_range(6, 4)));
            push(1'b0, cpol, int'($urandom_range(6, 4)));
        end
    endtask

    // Reference: every pin change becomes visible LAT cycles later; the frame is
    // tracked as selected/count, strobes follow the CPOL/CPHA edge table.
    task automatic run_queue(input int stop_at);
        int n;
        int cnt;
        bit sel, s3, k3, k4, is_lead, e_sh, e_sa, e_fd;
        n = q_ss.size();
        sel = 1'b0;
        cnt = 0;
        obs_sh = 0;
        obs_sa = 0;
        obs_fd = 0;
        for (int c = 0; c < n; c++) begin
            s3 = q_ss[(c >= LAT) ? c - LAT : 0];
            k3 = q_sck[(c >= LAT) ? c - LAT : 0];
            k4 = q_sck[(c >= LAT + 1) ? c - LAT - 1 : 0];
            e_sh = 1'b0;
            e_sa = 1'b0;
            e_fd = 1'b0;
            if (cnt == DW) cnt = 0;
            if (s3) begin
                sel = 1'b0;
                cnt = 0;
            end else if (!sel) begin
                sel = 1'b1;
                cnt = 0;
`ifdef SCK_IDLE_CHECK_EN
                m_err = (k3 != cpol);
`endif
                e_sh = !cpha && !m_err;
            end else if (k3 != k4 && !m_err) begin
                is_lead = (k3 != cpol);
                if (is_lead != cpha) begin
                    e_sa = 1'b1;
                    cnt++;
                    e_fd = (cnt == DW);
                end else begin
                    e_sh = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            ss_n   = q_ss[c];
            sck_in = q_sck[c];
            @(negedge clk);
            obs_sh += int'(shift_clk);
            obs_sa += int'(sample_clk);
            obs_fd += int'(frame_done);
            n_tests++;
            if ({shift_clk, sample_clk, frame_done, active, bit_cnt} !==
                {e_sh, e_sa, e_fd, sel, CW'(cnt)}) begin
                n_fail++;
                $display("FAIL cycle_%0d: got sh=%b sa=%b fd=%b act=%b cnt=%0d, expected sh=%b sa=%b fd=%b act=%b cnt=%0d",
                         c, shift_clk, sample_clk, frame_done, active, bit_cnt, e_sh, e_sa, e_fd, sel, cnt);
            end
`ifdef SCK_IDLE_CHECK_EN
            n_tests++;
            if (mode_err !== m_err) begin
                n_fail++;
                $display("FAIL mode_err_cycle_%0d: got %b expected %b", c, mode_err, m_err);
            end
`endif
            if (stop_at != 0 && obs_sa == stop_at) break;
        end
    endtask

    task automatic check_totals(input string name, input int sh, input int sa, input int fd);
        n_tests++;
        if (obs_sh != sh || obs_sa != sa || obs_fd != fd) begin
            n_fail++;
            $display("FAIL %s_totals: got shift=%0d sample=%0d done=%0d, expected shift=%0d sample=%0d done=%0d",
                     name, obs_sh, obs_sa, obs_fd, sh, sa, fd);
        end
    endtask

    task automatic build_frame(input int nb);
        q_clear();
        push(1'b1, cpol, 8);
        push(1'b0, cpol, int'($urandom_range(6, 3)));
        push_bits(nb);
        push(1'b1, cpol, 8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({shift_clk, sample_clk, frame_done, active, bit_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sh=%b sa=%b fd=%b act=%b cnt=%0d, expected all 0",
                     shift_clk, sample_clk, frame_done, active, bit_cnt);
        end
`ifdef SCK_IDLE_CHECK_EN
        n_tests++;
        if (mode_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mode_err: got %b expected 0", mode_err);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_mode0();
        cpol = 1'b0; cpha = 1'b0;
        build_frame(8);
        run_queue(0);
        check_totals("mode0", 9, 8, 1);
    endtask

    task automatic test_mode3();
        cpol = 1'b1; cpha = 1'b1;
        build_frame(8);
        run_queue(0);
        check_totals("mode3", 8, 8, 1);
    endtask

    task automatic test_back_to_back();
        cpol = 1'b0; cpha = 1'b1;
        build_frame(16);
        run_queue(0);
        check_totals("b2b_mode1", 16, 16, 2);
    endtask

    task automatic test_abort();
        cpol = 1'b1; cpha = 1'b0;
        q_clear();
        push(1'b1, cpol, 8);
        push(1'b0, cpol, 4);
        push_bits(5);
        push(1'b1, !cpol, 5);
        push(1'b1, cpol, 5);
        push(1'b1, !cpol, 5);
        push(1'b1, cpol, 8);
        run_queue(0);
        check_totals("abort_mode2", 6, 5, 0);
        n_tests++;
        if (bit_cnt !== '0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_final: got cnt=%0d act=%b expected cnt=0 act=0", bit_cnt, active);
        end
    endtask

    task automatic test_reset_midframe();
        cpol = 1'b0; cpha = 1'b0;
        build_frame(8);
        run_queue(4);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({shift_clk, sample_clk, frame_done, active, bit_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got sh=%b sa=%b fd=%b act=%b cnt=%0d, expected all 0",
                     shift_clk, sample_clk, frame_done, active, bit_cnt);
        end
        ss_n = 1'b1;
        sck_in = 1'b0;
        m_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        build_frame(8);
        run_queue(0);
        check_totals("restart_mode0", 9, 8, 1);
    endtask

`ifdef SCK_IDLE_CHECK_EN
    task automatic test_mode_err();
        cpol = 1'b0; cpha = 1'b0;
        q_clear();
        push(1'b1, 1'b0, 6);
        push(1'b1, 1'b1, 6);
        push(1'b0, 1'b1, 6);
        push_bits(3);
        push(1'b1, 1'b0, 8);
        run_queue(0);
        check_totals("bad_idle", 0, 0, 0);
        n_tests++;
        if (mode_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_err_set: got %b expected 1", mode_err);
        end
        build_frame(8);
        run_queue(0);
        check_totals("good_idle", 9, 8, 1);
        n_tests++;
        if (mode_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_err_clear: got %b expected 0", mode_err);
        end
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            cpol = 1'($urandom_range(1, 0));
            cpha = 1'($urandom_range(1, 0));
            q_clear();
            push(1'b1, cpol, 8);
            push(1'b0, cpol, int'($urandom_range(6, 3)));
            push_bits(int'($urandom_range(20, 1)));
            if ($urandom_range(1, 0) == 1) begin
                push(1'b0, !cpol, int'($urandom_range(6, 2)));
                push(1'b1, !cpol, 4);
            end
            push(1'b1, cpol, 8);
            run_queue(0);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
`ifdef SCK_IDLE_CHECK_EN
        test_mode_err();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_sck_ctrl.md
Name: spi_slave_sck_ctrl

Overview:
- Slave-side counterpart of the SPI master SCK generator.
- Takes the externally driven SCK and SS_n, synchronises them into the local clock domain and detects SCK edges according to CPOL/CPHA.
- Emits single-cycle Shift_clk / Sample_clk strobes, a bit counter and a frame-done pulse for the slave shift register.
- Sits between the SPI pins and the slave data path. Requires clk ≥ 4× SCK frequency.

Parameters:
- DATA_WIDTH, 8, bits per frame; bit_cnt wraps after this many sample strobes.
- SYNC_STAGES, 2, flip-flop stages on the SCK_in and SS_n inputs (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- SCK_in  input  1  raw serial clock from master, asynchronous.
- SS_n  input  1  raw slave select, active low, asynchronous.
- CPOL  input  1  clock idle level; static while SS_n is low.
- CPHA  input  1  clock phase; static while SS_n is low.
- Shift_clk  output  1  one-cycle strobe: drive the next MISO bit.
- Sample_clk  output  1  one-cycle strobe: capture MOSI.
- bit_cnt  output  $clog2(DATA_WIDTH)+1  sample strobes in the current frame.
- frame_done  output  1  one-cycle pulse on the DATA_WIDTH-th sample.
- active  output  1  high while synchronised SS_n is low.

Behaviour:
- Reset (async, rst_n=0): all sync flops = 1 (SS_n idle) and SCK sync = 0; Shift_clk=0, Sample_clk=0, bit_cnt=0, frame_done=0, active=0; FSM = IDLE.
- Synchronisers: SYNC_STAGES flops per input, plus one history flop on SCK for edge detection.
- Edge definitions:
  - lead = sync SCK changes from CPOL to !CPOL.
  - trail = sync SCK changes from !CPOL to CPOL.
  - Strobe latency is SYNC_STAGES+1 clk cycles after the raw pin edge.
- Strobe mapping:
  - CPHA=0: Sample_clk on lead; Shift_clk on trail; plus one extra Shift_clk in the cycle the FSM enters ARMED (first bit is presented before the first edge).
  - CPHA=1: Shift_clk on lead; Sample_clk on trail.
  - Shift_clk and Sample_clk are never high in the same cycle.
- FSM states:
  - IDLE: active=0, no strobes, SCK edges ignored. Goes to ARMED on sync SS_n falling.
  - ARMED: active=1; bit_cnt cleared to 0 on entry. Goes to XFER on first lead.
  - XFER: strobes per mapping. Each Sample_clk increments bit_cnt. When bit_cnt reaches DATA_WIDTH: frame_done pulses for one cycle, bit_cnt returns to 0, state goes to ARMED (back-to-back frames need no SS_n toggle).
  - Any state: sync SS_n high forces IDLE next cycle; bit_cnt cleared; no strobe is generated in that cycle.
- Boundaries:
  - SS_n deasserting mid-frame aborts the frame; frame_done is not pulsed and bit_cnt = 0.
  - SCK edge coincident with SS_n deassert: SS_n wins.
  - In CPHA=0 the trail following the final sample still produces Shift_clk (the slave data path loads the next byte there).
  - rst_n asserting mid-frame returns all outputs to reset values immediately.
  - CPOL/CPHA changes while active produce undefined strobes; there is no check unless the optional feature is built in.

Optional Feature:
- Macro SCK_IDLE_CHECK_EN.
- When defined:
  - Adds output mode_err (1 bit, reset 0).
  - In the cycle the FSM enters ARMED, if sync SCK != CPOL, mode_err is set sticky. It is cleared only by rst_n or by the next IDLE→ARMED entry with a correct idle level.
  - While mode_err=1, Shift_clk and Sample_clk are suppressed.
- When undefined: the port is absent and no check is made.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), SCK = clk/8, 8 bits: 1 Shift_clk at ARMED entry; 8 Sample_clk strobes, each 3 cycles after a raw rising edge; 8 Shift_clk on falling edges; frame_done once with bit_cnt=8→0.
- Mode 3 (CPOL=1, CPHA=1), 8 bits: Shift_clk on falling, Sample_clk on rising, 8 of each; no extra shift at select.
- Two back-to-back frames in Mode 1 with SS_n held low for 16 SCK cycles: frame_done pulses twice; bit_cnt resets between frames.
- SS_n raised after 5 samples in Mode 2: active drops 3 cycles later; bit_cnt=0; no frame_done; further SCK toggles give no strobes.
- rst_n pulsed low mid-frame at bit 4: all outputs 0 immediately; after release, a new SS_n fall restarts cleanly.
- With SCK_IDLE_CHECK_EN: CPOL=0 with SCK held high when SS_n falls → mode_err=1 and no strobes; reselect with SCK low → mode_err=0 and a normal 8-bit frame.
